// File: rtl/alu_pipe.sv
// Pipelined ALU: stage 1 computes result/flags/err and registers them with the tag,
// later stages are delay slots. Each stage keeps its own valid bit so bubbles collapse.
module alu_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 2,
  parameter int TAG_WIDTH  = 4,
  parameter int CMD_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [CMD_WIDTH-1:0]  in_cmd_i,
  input  logic [DATA_WIDTH-1:0] in_a_i,
  input  logic [DATA_WIDTH-1:0] in_b_i,
  input  logic [TAG_WIDTH-1:0]  in_tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_result_o,
  output logic [3:0]            out_flags_o,
  output logic                  out_err_o,
  output logic [TAG_WIDTH-1:0]  out_tag_o
);
  localparam int SHIFT_W   = $clog2(DATA_WIDTH);
  localparam int PAYLOAD_W = 1 + 4 + TAG_WIDTH + DATA_WIDTH;

  localparam logic [CMD_WIDTH-1:0] CMD_NOP   = 4'd0;
  localparam logic [CMD_WIDTH-1:0] CMD_ADD   = 4'd1;
  localparam logic [CMD_WIDTH-1:0] CMD_SUB   = 4'd2;
  localparam logic [CMD_WIDTH-1:0] CMD_AND   = 4'd3;
  localparam logic [CMD_WIDTH-1:0] CMD_OR    = 4'd4;
  localparam logic [CMD_WIDTH-1:0] CMD_XOR   = 4'd5;
  localparam logic [CMD_WIDTH-1:0] CMD_SHL   = 4'd6;
  localparam logic [CMD_WIDTH-1:0] CMD_SHR   = 4'd7;
  localparam logic [CMD_WIDTH-1:0] CMD_SRA   = 4'd8;
  localparam logic [CMD_WIDTH-1:0] CMD_SLT   = 4'd9;
  localparam logic [CMD_WIDTH-1:0] CMD_SLTU  = 4'd10;
  localparam logic [CMD_WIDTH-1:0] CMD_PASSB = 4'd11;

  logic [DATA_WIDTH:0]   add_sum;
  logic [DATA_WIDTH:0]   sub_sum;
  logic [SHIFT_W-1:0]    shamt;
  logic                  msb_a;
  logic                  msb_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [3:0]            alu_flags;
  logic                  alu_err;
  logic                  alu_c;
  logic                  alu_v;

  assign shamt   = in_b_i[SHIFT_W-1:0];
  assign msb_a   = in_a_i[DATA_WIDTH-1];
  assign msb_b   = in_b_i[DATA_WIDTH-1];
  assign add_sum = {1'b0, in_a_i} + {1'b0, in_b_i};
  // Subtraction as A + ~B + 1: carry-out of 1 means no borrow.
  assign sub_sum = {1'b0, in_a_i} + {1'b0, ~in_b_i} + (DATA_WIDTH+1)'(1);

  always_comb begin
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    alu_err    = 1'b0;
    case (in_cmd_i)
      CMD_NOP:   alu_result = '0;
      CMD_ADD: begin
        alu_result = add_sum[DATA_WIDTH-1:0];
        alu_c      = add_sum[DATA_WIDTH];
        alu_v      = (msb_a == msb_b) && (add_sum[DATA_WIDTH-1] != msb_a);
      end
      CMD_SUB: begin
        alu_result = sub_sum[DATA_WIDTH-1:0];
        alu_c      = !sub_sum[DATA_WIDTH];
        alu_v      = (msb_a != msb_b) && (sub_sum[DATA_WIDTH-1] != msb_a);
      end
      CMD_AND:   alu_result = in_a_i & in_b_i;
      CMD_OR:    alu_result = in_a_i | in_b_i;
      CMD_XOR:   alu_result = in_a_i ^ in_b_i;
      CMD_SHL:   alu_result = in_a_i << shamt;
      CMD_SHR:   alu_result = in_a_i >> shamt;
      CMD_SRA:   alu_result = $signed(in_a_i) >>> shamt;
      CMD_SLT:   alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(in_a_i) < $signed(in_b_i)};
      CMD_SLTU:  alu_result = {{(DATA_WIDTH-1){1'b0}}, in_a_i < in_b_i};
      CMD_PASSB: alu_result = in_b_i;
      default:   alu_err = 1'b1;
    endcase
    alu_flags = alu_err ? 4'b0000
                        : {alu_result[DATA_WIDTH-1], alu_result == '0, alu_c, alu_v};
  end

  logic [STAGES-1:0]    valid_reg;
  logic [PAYLOAD_W-1:0] payload_reg [STAGES];
  logic [STAGES-1:0]    load;
  logic                 in_fire;

  // A stage loads when empty or when its contents move on; walk from the output back.
  always_comb begin
    load = '0;
    load[STAGES-1] = !valid_reg[STAGES-1] || out_ready_i;
    for (int k = STAGES - 2; k >= 0; k--) begin
      load[k] = !valid_reg[k] || load[k+1];
    end
  end

  assign in_ready_o = load[0] && !rst_i;
  assign in_fire    = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        payload_reg[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_reg[0] <= in_fire;
        if (in_fire) begin
          payload_reg[0] <= {alu_err, alu_flags, in_tag_i, alu_result};
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          valid_reg[k] <= valid_reg[k-1];
          if (valid_reg[k-1]) begin
            payload_reg[k] <= payload_reg[k-1];
          end
        end
      end
    end
  end

  // The output is masked during reset so nothing is handed over in the cycle being flushed.
  assign out_valid_o = valid_reg[STAGES-1] && !rst_i;
  assign {out_err_o, out_flags_o, out_tag_o, out_result_o} = payload_reg[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: four instances (STAGES 1..4) exercised one at a time with a
// directed vector table, backpressure and mid-stream reset sequences, and random traffic.
`timescale 1ns/1ps
module tb_alu_pipe;
  localparam int W  = 16;
  localparam int TW = 4;
  localparam int NI = 4;
  localparam int NT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst        [NI];
  logic          in_valid   [NI];
  logic          in_ready   [NI];
  logic [3:0]    in_cmd     [NI];
  logic [W-1:0]  in_a       [NI];
  logic [W-1:0]  in_b       [NI];
  logic [TW-1:0] in_tag     [NI];
  logic          out_valid  [NI];
  logic          out_ready  [NI];
  logic [W-1:0]  out_result [NI];
  logic [3:0]    out_flags  [NI];
  logic          out_err    [NI];
  logic [TW-1:0] out_tag    [NI];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      alu_pipe #(.DATA_WIDTH(W), .STAGES(gi + 1), .TAG_WIDTH(TW), .CMD_WIDTH(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst[gi]),
        .in_valid_i   (in_valid[gi]),
        .in_ready_o   (in_ready[gi]),
        .in_cmd_i     (in_cmd[gi]),
        .in_a_i       (in_a[gi]),
        .in_b_i       (in_b[gi]),
        .in_tag_i     (in_tag[gi]),
        .out_valid_o  (out_valid[gi]),
        .out_ready_i  (out_ready[gi]),
        .out_result_o (out_result[gi]),
        .out_flags_o  (out_flags[gi]),
        .out_err_o    (out_err[gi]),
        .out_tag_o    (out_tag[gi])
      );
    end
  endgenerate

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         err;
  } alu_out_t;

  typedef struct {
    logic [3:0]   cmd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         err;
  } vec_t;

  vec_t tbl [NT];
  int   passed = 0;
  int   total  = 0;
  int   cur_stages = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (STAGES=%0d): got %h, expected %h", name, cur_stages, act, exp);
  endtask

  // Reference ALU from the arithmetic rules, using plain integer math.
  function automatic alu_out_t ref_alu(logic [3:0] cmd, logic [W-1:0] a, logic [W-1:0] b);
    alu_out_t o;
    int ua, ub, sa, sb, r, s;
    bit c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = ub % W;
    r  = 0;
    c  = 0;
    v  = 0;
    o.err = 0;
    case (cmd)
      4'd0:  r = 0;
      4'd1: begin
        r = ua + ub;
        c = (r > (1 << W) - 1);
        v = (sa + sb > (1 << (W-1)) - 1) || (sa + sb < -(1 << (W-1)));
      end
      4'd2: begin
        r = ua - ub;
        c = (ua < ub);
        v = (sa - sb > (1 << (W-1)) - 1) || (sa - sb < -(1 << (W-1)));
      end
      4'd3:  r = ua & ub;
      4'd4:  r = ua | ub;
      4'd5:  r = ua ^ ub;
      4'd6:  r = ua << s;
      4'd7:  r = ua >> s;
      4'd8:  r = sa >>> s;
      4'd9:  r = (sa < sb) ? 1 : 0;
      4'd10: r = (ua < ub) ? 1 : 0;
      4'd11: r = ub;
      default: o.err = 1;
    endcase
    o.res   = W'(r);
    o.flags = o.err ? 4'b0000 : {o.res[W-1], o.res == '0, c, v};
    return o;
  endfunction

  task automatic do_reset(int i);
    rst[i] = 1'b1;
    in_valid[i] = 1'b0;
    out_ready[i] = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready[i], 0);
    chk("rst_out_valid", out_valid[i], 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_data", {out_result[i], out_flags[i], out_err[i], out_tag[i]}, 0);
    @(posedge clk); #1;
    rst[i] = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready[i], 1);
    chk("post_rst_out_valid", out_valid[i], 0);
    @(posedge clk); #1;
  endtask

  // Back-to-back table stream with the consumer always ready.
  task automatic stream_table(int i);
    int stg = i + 1;
    int sent = 0;
    int got = 0;
    int acc_cyc [NT];
    out_ready[i] = 1'b1;
    for (int cyc = 0; cyc < 100 && got < NT; cyc++) begin
      in_valid[i] = (sent < NT);
      if (sent < NT) begin
        in_cmd[i] = tbl[sent].cmd;
        in_a[i]   = tbl[sent].a;
        in_b[i]   = tbl[sent].b;
        in_tag[i] = TW'(sent);
      end
      @(negedge clk);
      if (sent < NT) chk("thru_in_ready", in_ready[i], 1);
      if (in_valid[i] && in_ready[i]) begin
        acc_cyc[sent] = cyc;
        sent++;
      end
      if (out_valid[i] && out_ready[i]) begin
        chk("vec_out", {out_result[i], out_flags[i], out_err[i], out_tag[i]},
            {tbl[got].res, tbl[got].flags, tbl[got].err, TW'(got)});
        chk("vec_latency", cyc - acc_cyc[got], stg);
        $display("vec S=%0d tag=%0h cmd=%0d a=%h b=%h res=%h flags=%b err=%b", stg,
                 out_tag[i], tbl[got].cmd, tbl[got].a, tbl[got].b, out_result[i],
                 out_flags[i], out_err[i]);
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid[i] = 1'b0;
    chk("vec_count", got, NT);
  endtask

  // Six ops; consumer stalls five cycles, then toggles ready every cycle.
  task automatic bp_test(int i);
    int stg = i + 1;
    int sent = 0;
    int got = 0;
    bit drop_seen = 0;
    bit prev_stall = 0;
    logic [3:0]   c  [6];
    logic [W-1:0] av [6];
    logic [W-1:0] bv [6];
    logic [24:0]  prev_out = '0;
    logic [24:0]  cur_out;
    alu_out_t e;
    for (int k = 0; k < 6; k++) begin
      c[k]  = 4'(k + 1);
      av[k] = W'($urandom);
      bv[k] = W'($urandom);
    end
    for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
      out_ready[i] = (cyc < 5) ? 1'b0 : ((cyc - 5) % 2 == 0);
      in_valid[i] = (sent < 6);
      if (sent < 6) begin
        in_cmd[i] = c[sent];
        in_a[i]   = av[sent];
        in_b[i]   = bv[sent];
        in_tag[i] = TW'(sent);
      end
      @(negedge clk);
      cur_out = {out_result[i], out_flags[i], out_err[i], out_tag[i]};
      if (prev_stall) chk("bp_stable", {out_valid[i], cur_out}, {1'b1, prev_out});
      if (!drop_seen && in_valid[i] && !in_ready[i]) begin
        drop_seen = 1;
        chk("bp_ready_drop", sent, stg);
      end
      if (in_valid[i] && in_ready[i]) sent++;
      if (out_valid[i] && out_ready[i]) begin
        e = ref_alu(c[got], av[got], bv[got]);
        chk("bp_out", cur_out, {e.res, e.flags, e.err, TW'(got)});
        $display("bp  S=%0d tag=%0h cmd=%0d res=%h flags=%b", stg, out_tag[i], c[got],
                 out_result[i], out_flags[i]);
        got++;
      end
      prev_stall = out_valid[i] && !out_ready[i];
      prev_out = cur_out;
      @(posedge clk); #1;
    end
    in_valid[i] = 1'b0;
    chk("bp_count", got, 6);
    chk("bp_drop_seen", drop_seen, 1);
  endtask

  // Two ops in flight, one-cycle reset pulse, then a single op must come out alone.
  task automatic mrst_test(int i);
    int stg = i + 1;
    int n_out = 0;
    int lat = -1;
    out_ready[i] = 1'b0;
    in_valid[i] = 1'b1;
    in_cmd[i] = 4'd1;
    in_a[i] = 16'd10;
    in_b[i] = 16'd20;
    in_tag[i] = 4'hA;
    @(negedge clk);
    @(posedge clk); #1;
    in_tag[i] = 4'hB;
    in_a[i] = 16'd30;
    @(negedge clk);
    @(posedge clk); #1;
    rst[i] = 1'b1;
    out_ready[i] = 1'b1;
    in_tag[i] = 4'hD;
    @(negedge clk);
    chk("mrst_out_valid_in_rst", out_valid[i], 0);
    chk("mrst_in_ready_in_rst", in_ready[i], 0);
    @(posedge clk); #1;
    rst[i] = 1'b0;
    in_cmd[i] = 4'd1;
    in_a[i] = 16'd2;
    in_b[i] = 16'd3;
    in_tag[i] = 4'hC;
    @(negedge clk);
    chk("mrst_in_ready_after", in_ready[i], 1);
    chk("mrst_out_valid_after", out_valid[i], 0);
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (out_valid[i]) begin
        n_out++;
        if (lat < 0) lat = k;
        chk("mrst_out", {out_result[i], out_flags[i], out_err[i], out_tag[i]},
            {16'd5, 4'b0000, 1'b0, 4'hC});
        $display("mrst S=%0d tag=%0h res=%h latency=%0d", stg, out_tag[i], out_result[i], k);
      end
      @(posedge clk); #1;
    end
    chk("mrst_alone", n_out, 1);
    chk("mrst_latency", lat, stg);
  endtask

  // Random commands/operands with random valid and ready, scored against ref_alu.
  task automatic rnd_test(int i, int n);
    alu_out_t       expq [$];
    logic [TW-1:0]  tagq [$];
    alu_out_t       e;
    logic [TW-1:0]  t;
    int sent = 0;
    int got = 0;
    bit pending = 0;
    for (int cyc = 0; cyc < 40 * n && got < n; cyc++) begin
      if (!pending && sent < n && $urandom_range(0, 3) != 0) begin
        pending = 1;
        in_cmd[i] = 4'($urandom_range(0, 15));
        in_a[i]   = W'($urandom);
        in_b[i]   = W'($urandom);
        in_tag[i] = TW'(sent);
      end
      in_valid[i] = pending;
      out_ready[i] = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (in_valid[i] && in_ready[i]) begin
        expq.push_back(ref_alu(in_cmd[i], in_a[i], in_b[i]));
        tagq.push_back(in_tag[i]);
        pending = 0;
        sent++;
      end
      if (out_valid[i] && out_ready[i]) begin
        if (expq.size() == 0) begin
          chk("rnd_output_has_pending_op", (sent - got) > 0, 1);
        end else begin
          e = expq.pop_front();
          t = tagq.pop_front();
          chk("rnd_out", {out_result[i], out_flags[i], out_err[i], out_tag[i]},
              {e.res, e.flags, e.err, t});
          $display("rnd S=%0d tag=%0h res=%h flags=%b err=%b", i + 1, out_tag[i],
                   out_result[i], out_flags[i], out_err[i]);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid[i] = 1'b0;
    chk("rnd_count", got, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1;
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
      in_cmd[i] = '0;
      in_a[i] = '0;
      in_b[i] = '0;
      in_tag[i] = '0;
    end
    tbl[0]  = '{4'd1,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0};
    tbl[1]  = '{4'd1,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b0};
    tbl[2]  = '{4'd2,  16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1'b0};
    tbl[3]  = '{4'd9,  16'h8000, 16'h0001, 16'h0001, 4'b0000, 1'b0};
    tbl[4]  = '{4'd10, 16'h8000, 16'h0001, 16'h0000, 4'b0100, 1'b0};
    tbl[5]  = '{4'd8,  16'h8000, 16'h0013, 16'hF000, 4'b1000, 1'b0};
    tbl[6]  = '{4'd6,  16'h0001, 16'h000F, 16'h8000, 4'b1000, 1'b0};
    tbl[7]  = '{4'd7,  16'h1234, 16'h0000, 16'h1234, 4'b0000, 1'b0};
    tbl[8]  = '{4'd13, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1'b1};
    tbl[9]  = '{4'd0,  16'h1234, 16'h5678, 16'h0000, 4'b0100, 1'b0};
    tbl[10] = '{4'd11, 16'h1234, 16'h8001, 16'h8001, 4'b1000, 1'b0};
    tbl[11] = '{4'd5,  16'h5555, 16'h5555, 16'h0000, 4'b0100, 1'b0};
    tbl[12] = '{4'd3,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0};
    tbl[13] = '{4'd4,  16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 1'b0};
    tbl[14] = '{4'd2,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b0};
    tbl[15] = '{4'd1,  16'h8000, 16'h8000, 16'h0000, 4'b0111, 1'b0};

    for (int i = 0; i < NI; i++) begin
      cur_stages = i + 1;
      do_reset(i);
      stream_table(i);
      do_reset(i);
      bp_test(i);
      do_reset(i);
      mrst_test(i);
      do_reset(i);
      rnd_test(i, 150);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined ALU. It succeeds the 3-bit-command, 16-bit combinational ALU task format. The block accepts one command plus two operands per cycle over a valid/ready handshake and returns result, status flags and a pass-through tag after `STAGES` cycles. Backpressure from the consumer is absorbed stage by stage, and internal bubbles are collapsed. It sits between the decode/operand-fetch stage and writeback in the RISC-16 datapath.

## Interface

**Parameters**
- `DATA_WIDTH`, 16: operand and result width; must be ≥ 4 and a power of 2.
- `STAGES`, 2: pipeline depth; legal range 1..4.
- `TAG_WIDTH`, 4: width of the opaque tag carried alongside each operation.
- `CMD_WIDTH`, 4: command width; fixed at 4.

**Ports**
- `clk_i` input 1: the only clock.
- `rst_i` input 1: synchronous, active-high reset.
- `in_valid_i` input 1: an operation is offered.
- `in_ready_o` output 1: the block can accept an operation this cycle.
- `in_cmd_i` input CMD_WIDTH: operation code.
- `in_a_i` input DATA_WIDTH: operand A.
- `in_b_i` input DATA_WIDTH: operand B; its low log2(DATA_WIDTH) bits are the shift amount.
- `in_tag_i` input TAG_WIDTH: tag returned unchanged with the result.
- `out_valid_o` output 1: a result is presented.
- `out_ready_i` input 1: the consumer accepts the result.
- `out_result_o` output DATA_WIDTH: result.
- `out_flags_o` output 4: {N, Z, C, V}.
- `out_err_o` output 1: the command was illegal.
- `out_tag_o` output TAG_WIDTH: tag of the presented result.

## Operation

**Command encoding.** Codes 0..5 are unchanged from the 3-bit set, zero-extended to 4 bits.
- 0 NOP: result 0.
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
- 6 SHL: logical shift left.
- 7 SHR: logical shift right.
- 8 SRA: arithmetic shift right.
- 9 SLT: signed A < B gives 1, else 0.
- 10 SLTU: unsigned A < B gives 1, else 0.
- 11 PASSB: result = B.
- 12..15 are illegal: result 0, all flags 0, `out_err_o` = 1.

**Arithmetic rules.**
- All arithmetic is modulo 2^DATA_WIDTH.
- ADD: C = carry-out of the DATA_WIDTH-bit sum. V = signed overflow.
- SUB: computed as A + ~B + 1. C = borrow, i.e. 1 when A < B unsigned. V = signed overflow.
- Shifts use only `b[log2(DATA_WIDTH)-1:0]`; upper bits of B are ignored. A shift by 0 returns A.
- Z = (result == 0) and N = result MSB, for every legal command.
- C and V are 0 for every command other than ADD and SUB.

**Pipeline structure.**
- Stage 1 registers the computed result, flags, err and tag.
- Stages 2..STAGES are delay registers. Each stage holds its own valid bit.
- Stage k loads when it is empty, or when its contents leave this cycle.
- The last stage's contents leave when `out_valid_o` and `out_ready_i` are both 1.

**Handshake rules.**
- An input transfer occurs when `in_valid_i` and `in_ready_o` are both 1 at the rising edge.
- `in_ready_o` = stage 1 empty, or stage 1 advancing. It is combinational from `out_ready_i` through the stage valid bits; no combinational path exists from `in_valid_i` to `in_ready_o`.
- `in_ready_o` = 0 whenever `rst_i` = 1.
- The producer holds `in_*` stable while `in_valid_i` = 1 and `in_ready_o` = 0. The consumer sees `out_*` held stable while `out_valid_o` = 1 and `out_ready_i` = 0.
- Ordering is strictly FIFO. Nothing is dropped or duplicated.
- NOP is a real transaction: it occupies a slot and produces an output with Z = 1.

**Reset.**
- All stage valid bits clear to 0. `out_valid_o` = 0.
- `out_result_o`, `out_flags_o`, `out_err_o` and `out_tag_o` read 0.
- Reset asserted mid-stream discards every in-flight operation at the next edge.
- The first cycle after `rst_i` deasserts has `in_ready_o` = 1.

## Timing

- Latency: an operation accepted at edge n is presented at edge n+STAGES when there is no backpressure.
- Throughput: one operation per cycle, sustained with `out_ready_i` held at 1.
- Capacity: STAGES operations in flight.
  - With `out_ready_i` = 0, `in_ready_o` falls only once all STAGES slots are full.
  - Bubbles ahead of a stalled stage fill first.
- Full pipeline with `out_ready_i` = 1 and `in_valid_i` = 1: accept and emit in the same cycle; occupancy is unchanged.
- Empty pipeline: `out_valid_o` = 0. The output data hold their last value; that value is not checked.
- STAGES = 1: the result is registered once. `in_ready_o` = !out_valid_o || out_ready_i.

## Test plan

- **Reset:** reset, then ADD a=0x7FFF b=0x0001 tag=3 with `out_ready_i`=1.
  - Result 0x8000 at edge n+2; N=1, Z=0, C=0, V=1; tag 3.
- **Carry and borrow:**
  - ADD 0xFFFF+0x0001 gives 0x0000 with Z=1, C=1, V=0.
  - SUB 0x0003−0x0005 gives 0xFFFE with C=1, N=1.
  - SLT 0x8000,0x0001 gives 1; SLTU with the same operands gives 0.
- **Shifts (DATA_WIDTH=16):**
  - SRA 0x8000 by b=0x0013 gives 0xF000; shift amount 3, upper bits of b ignored.
  - SHL 0x0001 by 15 gives 0x8000.
  - SHR by 0 returns A.
- **Backpressure:** stream 6 ops with tags 0..5. Hold `out_ready_i`=0 for 5 cycles, then toggle it every cycle.
  - `in_ready_o` drops after exactly STAGES accepts.
  - All 6 results emerge in tag order with no loss and no duplicates.
  - Outputs stay stable while stalled.
- **Illegal command and NOP:**
  - cmd 13 gives result 0, flags 0, err=1.
  - NOP gives result 0, Z=1, err=0.
- **Mid-stream reset:** with 2 ops in flight, pulse `rst_i` for 1 cycle.
  - `out_valid_o`=0 and `in_ready_o`=0 during the reset cycle.
  - The next accepted op emerges alone after STAGES cycles.
  - Repeat for STAGES = 1, 3 and 4.
